des_pipe_scheduler: RTL

- Front-end controller for the 18-stage pipelined DES core.
- Arbitrates up to NUM_REQ requesters round-robin onto the single DES pipeline, one block per cycle.
- Tags each accepted block with its requester ID and tracks it through the pipeline with a valid/tag shift register.
- Returns each result on a valid/ready response port and drives the core's global en as the pipeline stall under output backpressure.

---
 rtl/des_pkg.sv | 21 ++
 rtl/des_pipe_scheduler_rr_arbiter.sv | 48 ++++
 rtl/des_pipe_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES constants, block/key types and the FIPS reference vector.
// Combinational helpers only; no state lives here.
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_KEY_W   = 64;
    localparam int DES_LATENCY = 18;

    typedef logic [DES_BLOCK_W-1:0] des_block_t;
    typedef logic [DES_KEY_W-1:0]   des_key_t;

    localparam des_block_t FIPS_PT  = 64'h0123_4567_89AB_CDEF;
    localparam des_key_t   FIPS_KEY = 64'h1334_5779_9BBC_DFF1;
    localparam des_block_t FIPS_CT  = 64'h85E8_1354_0F0A_B405;

    // Modulo-n increment for pointers that never exceed n-1.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/des_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter, combinational grant in the request cycle (0 cycles).
// No internal backpressure: the caller masks req to suppress grants; pointer moves only on advance.
module rr_arbiter
    import des_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic [N-1:0]     onehot;
    int               k;

    // Walk from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        onehot    = '0;
        k         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            onehot = N'(1) << k;
            if (|(req & onehot)) begin
                grant     = onehot;
                grant_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= IDX_W'(wrap_inc(int'(grant_idx), N));
        end
    end

endmodule

// File: rtl/des_pipe_scheduler.sv
// Schedules requesters onto the DES pipeline and tags results; LATENCY en-qualified cycles accept->rsp.
// Backpressure: a held response drops des_en and all req_ready until rsp_ready returns.
module des_pipe_scheduler
    import des_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = DES_LATENCY,
    parameter int ID_W    = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DES_BLOCK_W-1:0] req_text,
    input  logic [NUM_REQ*DES_KEY_W-1:0]   req_key,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DES_BLOCK_W-1:0]         rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           des_en,
    output logic [DES_BLOCK_W-1:0]         des_text,
    output logic [DES_KEY_W-1:0]           des_key,
    input  logic [DES_BLOCK_W-1:0]         des_ct,
    output logic [$clog2(LATENCY+1)-1:0]   inflight,
    output logic                           busy
);

    logic [LATENCY-1:0] vld_sr;
    logic [ID_W-1:0]    tag_sr [LATENCY];
    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               stall;
    logic               accept;
    logic               rsp_hs;

    assign stall    = vld_sr[LATENCY-1] & ~rsp_ready;
    // Grants are withheld while the tail is stuck and while reset is asserted.
    assign req_elig = req_valid & {NUM_REQ{~stall & reset_n}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_elig),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign busy      = (inflight != '0);
    assign des_en    = ~stall & (accept | busy);

    assign rsp_valid = vld_sr[LATENCY-1];
    assign rsp_id    = tag_sr[LATENCY-1];
    assign rsp_data  = des_ct;
    assign rsp_hs    = rsp_valid & rsp_ready;

    always_comb begin
        des_text = '0;
        des_key  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                des_text = req_text[r*DES_BLOCK_W +: DES_BLOCK_W];
                des_key  = req_key[r*DES_KEY_W +: DES_KEY_W];
            end
        end
    end

    // Tracking registers advance in lockstep with the core, so a tag always sits beside its block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_sr   <= '0;
            inflight <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            if (des_en) begin
                vld_sr    <= {vld_sr[LATENCY-2:0], accept};
                tag_sr[0] <= grant_idx;
                for (int i = 1; i < LATENCY; i++) begin
                    tag_sr[i] <= tag_sr[i-1];
                end
            end
            case ({accept, rsp_hs})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
